// File: rtl/shake_padder.sv
// shake_padder: packs 64-bit message words into one SHAKE rate block, applies
// SHAKE domain padding (0x1F ... 0x80) and offers the block to the Keccak core.
module shake_padder (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic [63:0]   din,
  input  logic          din_valid,
  input  logic          din_last,
  input  logic [3:0]    din_nbytes,
  output logic          din_ready,
  output logic [1343:0] blk,
  output logic          blk_valid,
  input  logic          blk_ack,
  output logic          msg_done
);

  localparam int unsigned W       = 64;
  localparam int unsigned WORDS_G = 21;
  localparam int unsigned WORDS_H = 17;
  localparam int unsigned BLK_W   = W * WORDS_G;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned POS_W   = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    FULL   = 2'd1,
    PADBLK = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic               mode_h_q, mode_h_d;
  logic               in_msg_q, in_msg_d;
  logic               final_q, final_d;
  logic               pad_pend_q, pad_pend_d;
  logic               din_ready_q, din_ready_d;
  logic               blk_valid_q, blk_valid_d;
  logic               msg_done_q, msg_done_d;

  logic               mode_h_c;
  logic [CNT_W-1:0]   rw_c;
  logic [3:0]         nb_c;
  logic [W-1:0]       din_masked_c;
  logic [POS_W-1:0]   pad_pos_c;
  logic [POS_W-1:0]   last_pos_c;

  // Mode is live only for the first word of a message, then held.
  always_comb begin
    mode_h_c   = in_msg_q ? mode_h_q : (mode != 2'b00);
    rw_c       = mode_h_c ? CNT_W'(WORDS_H) : CNT_W'(WORDS_G);
    nb_c       = (din_nbytes > 4'd8) ? 4'd8 : din_nbytes;
    pad_pos_c  = {wcnt_q, 3'b000} + POS_W'(nb_c);
    last_pos_c = {rw_c, 3'b000} - POS_W'(1);
  end

  // Keep only the valid bytes of the final word.
  always_comb begin
    din_masked_c = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      if (4'(j) < nb_c) din_masked_c[8*j +: 8] = din[8*j +: 8];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      blk_q       <= '0;
      wcnt_q      <= '0;
      mode_h_q    <= 1'b0;
      in_msg_q    <= 1'b0;
      final_q     <= 1'b0;
      pad_pend_q  <= 1'b0;
      din_ready_q <= 1'b1;
      blk_valid_q <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      wcnt_q      <= wcnt_d;
      mode_h_q    <= mode_h_d;
      in_msg_q    <= in_msg_d;
      final_q     <= final_d;
      pad_pend_q  <= pad_pend_d;
      din_ready_q <= din_ready_d;
      blk_valid_q <= blk_valid_d;
      msg_done_q  <= msg_done_d;
    end
  end

  // Next-state, buffer writes and padding insertion.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    wcnt_d      = wcnt_q;
    mode_h_d    = mode_h_q;
    in_msg_d    = in_msg_q;
    final_d     = final_q;
    pad_pend_d  = pad_pend_q;
    din_ready_d = din_ready_q;
    blk_valid_d = blk_valid_q;
    msg_done_d  = 1'b0;

    unique case (state_q)
      FILL: begin
        if (din_valid) begin
          mode_h_d = mode_h_c;
          in_msg_d = 1'b1;
          if (din_last) begin
            blk_d[{wcnt_q, 6'b000000} +: W] = din_masked_c;
            if (pad_pos_c == {rw_c, 3'b000}) begin
              // Block exactly full: padding goes into a block of its own.
              pad_pend_d = 1'b1;
              final_d    = 1'b0;
            end else begin
              blk_d[{pad_pos_c, 3'b000} +: 8]  = blk_d[{pad_pos_c, 3'b000} +: 8] ^ 8'h1F;
              blk_d[{last_pos_c, 3'b000} +: 8] = blk_d[{last_pos_c, 3'b000} +: 8] ^ 8'h80;
              final_d = 1'b1;
            end
            state_d     = FULL;
            din_ready_d = 1'b0;
            blk_valid_d = 1'b1;
          end else begin
            blk_d[{wcnt_q, 6'b000000} +: W] = din;
            wcnt_d = wcnt_q + CNT_W'(1);
            if (wcnt_q == rw_c - CNT_W'(1)) begin
              state_d     = FULL;
              din_ready_d = 1'b0;
              blk_valid_d = 1'b1;
            end
          end
        end
      end
      FULL: begin
        if (blk_ack) begin
          blk_d       = '0;
          wcnt_d      = '0;
          blk_valid_d = 1'b0;
          if (pad_pend_q) begin
            state_d = PADBLK;
          end else begin
            state_d     = FILL;
            din_ready_d = 1'b1;
            if (final_q) begin
              msg_done_d = 1'b1;
              final_d    = 1'b0;
              in_msg_d   = 1'b0;
            end
          end
        end
      end
      PADBLK: begin
        blk_d = '0;
        blk_d[7:0] = 8'h1F;
        blk_d[{last_pos_c, 3'b000} +: 8] = 8'h80;
        final_d     = 1'b1;
        pad_pend_d  = 1'b0;
        state_d     = FULL;
        blk_valid_d = 1'b1;
      end
      default: begin
        state_d     = FILL;
        din_ready_d = 1'b1;
        blk_valid_d = 1'b0;
      end
    endcase
  end

  assign din_ready = din_ready_q;
  assign blk       = blk_q;
  assign blk_valid = blk_valid_q;
  assign msg_done  = msg_done_q;

endmodule

// File: tb/tb_shake_padder.sv
// tb_shake_padder: random and directed messages checked against a byte-level
// SHAKE padding model through an expected-block scoreboard.
`timescale 1ns/1ps
module tb_shake_padder;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [63:0]   din;
  logic          din_valid;
  logic          din_last;
  logic [3:0]    din_nbytes;
  logic          din_ready;
  logic [1343:0] blk;
  logic          blk_valid;
  logic          blk_ack;
  logic          msg_done;

  shake_padder dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_nbytes (din_nbytes),
    .din_ready  (din_ready),
    .blk        (blk),
    .blk_valid  (blk_valid),
    .blk_ack    (blk_ack),
    .msg_done   (msg_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1343:0] blk;
    bit            fin;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   msgs_sent = 0;
  int   done_seen = 0;
  bit   hold_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [1343:0] act, input logic [1343:0] exp);
    tests++;
    if (act !== exp) begin
      int k = 0;
      while (k < 20 && act[64*k +: 64] === exp[64*k +: 64]) k++;
      fails++;
      $display("FAIL %s: word %0d got %h expected %h", name, k, act[64*k +: 64], exp[64*k +: 64]);
    end
  endtask

  // Reference: msg || 0x1F || 0* || (last byte ^= 0x80), cut into rate-sized blocks.
  task automatic push_msg(input logic [7:0] msg[$], input bit h);
    int rate;
    int total;
    logic [7:0] pb[$];
    exp_t e;
    rate  = h ? 136 : 168;
    total = (msg.size() / rate + 1) * rate;
    pb = msg;
    pb.push_back(8'h1F);
    while (pb.size() < total) pb.push_back(8'h00);
    pb[total-1] = pb[total-1] ^ 8'h80;
    for (int b = 0; b < total / rate; b++) begin
      e.blk = '0;
      for (int i = 0; i < rate; i++) e.blk[8*i +: 8] = pb[b*rate + i];
      e.fin = (b == total / rate - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input bit last, input logic [3:0] nb);
    int n = 0;
    din = d; din_last = last; din_nbytes = nb; din_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!din_ready && n < 5000);
    check("din_accept_timeout", 64'(n < 5000), 64'd1);
    tick();
    din_valid = 1'b0; din_last = 1'b0;
    din = {$urandom, $urandom}; din_nbytes = 4'($urandom);
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input logic [1:0] md, input bit allow_extra);
    int L;
    int nw;
    int nb;
    logic [63:0] d;
    logic [3:0] nbv;
    L  = msg.size();
    nw = (L == 0) ? 1 : (L + 7) / 8;
    if (allow_extra && L > 0 && L % 8 == 0 && $urandom_range(0, 3) == 0) nw++;
    mode = md;
    push_msg(msg, md != 2'b00);
    msgs_sent++;
    for (int w = 0; w < nw; w++) begin
      nb = L - 8*w;
      if (nb > 8) nb = 8;
      for (int j = 0; j < 8; j++) d[8*j +: 8] = (j < nb) ? msg[8*w + j] : 8'($urandom);
      nbv = (nb == 8 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(8, 15)) : 4'(nb);
      repeat ($urandom_range(0, 2)) tick();
      send_word(d, w == nw - 1, nbv);
      if (w == 0) mode = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic rand_msg(input int L, output logic [7:0] m[$]);
    m = {};
    for (int i = 0; i < L; i++) m.push_back(8'($urandom));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!blk_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(blk_valid), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic hold_on();
    hold_ack = 1'b1;
    repeat (2) tick();
  endtask

  // Random acknowledge, including acks while no block is offered.
  initial begin
    blk_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      blk_ack = hold_ack ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pop expected block on each handshake, check msg_done and stability.
  initial begin
    exp_t          e;
    logic [1343:0] prev_blk = '0;
    bit            prev_v = 1'b0;
    bit            prev_ack = 1'b0;
    bit            exp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0; prev_ack = 1'b0; exp_done = 1'b0;
        continue;
      end
      check("msg_done", 64'(msg_done), 64'(exp_done));
      if (msg_done) done_seen++;
      exp_done = 1'b0;
      if (blk_valid) begin
        check("ready_low_while_valid", 64'(din_ready), 64'd0);
        if (prev_v && !prev_ack) check_blk("blk_stable", blk, prev_blk);
        if (blk_ack) begin
          if (exp_q.size() == 0) begin
            check("unexpected_block", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_blk("blk", blk, e.blk);
            exp_done = e.fin;
          end
        end
      end
      prev_v = blk_valid; prev_ack = blk_ack; prev_blk = blk;
    end
  end

  initial begin
    logic [7:0]    m[$];
    logic [7:0]    m2[$];
    logic [1343:0] c;
    logic [1343:0] saved;
    int            L;
    int            rate;

    reset = 1'b1; mode = 2'b00; din = '0; din_valid = 1'b0;
    din_last = 1'b0; din_nbytes = 4'd0;
    repeat (3) tick();
    @(negedge clk);
    check_blk("reset_blk", blk, '0);
    check("reset_blk_valid", 64'(blk_valid), 64'd0);
    check("reset_din_ready", 64'(din_ready), 64'd1);
    check("reset_msg_done", 64'(msg_done), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Empty message, SHAKE128.
    hold_on();
    m = {};
    send_msg(m, 2'b00, 1'b0);
    wait_valid("t1_valid");
    c = '0; c[7:0] = 8'h1F; c[167*8 +: 8] = 8'h80;
    check_blk("t1_empty_block", blk, c);
    hold_ack = 1'b0;
    drain();

    // 3-byte message, SHAKE256.
    hold_on();
    m = {8'hAA, 8'hBB, 8'hCC};
    send_msg(m, 2'b10, 1'b0);
    wait_valid("t2_valid");
    c = '0; c[31:0] = 32'h1FCCBBAA; c[135*8 +: 8] = 8'h80;
    check_blk("t2_three_bytes", blk, c);
    hold_ack = 1'b0;
    drain();

    // 135 bytes in SHAKE256: both pad bytes collide into 0x9F.
    hold_on();
    rand_msg(135, m);
    send_msg(m, 2'b10, 1'b0);
    wait_valid("t3_valid");
    check("t3_byte135", 64'(blk[135*8 +: 8]), 64'h9F);
    check("t3_byte136", 64'(blk[136*8 +: 8]), 64'h00);
    hold_ack = 1'b0;
    drain();

    // Exactly 21 full words in SHAKE128: data block then pad-only block.
    rand_msg(168, m);
    send_msg(m, 2'b00, 1'b0);
    drain();

    // Hold ack low for 10 cycles with the next message waiting on din.
    hold_on();
    rand_msg(3, m);
    send_msg(m, 2'b00, 1'b0);
    wait_valid("t5_valid");
    tick();
    saved = blk;
    rand_msg(20, m2);
    fork
      send_msg(m2, 2'b10, 1'b1);
      begin
        repeat (10) begin
          @(negedge clk);
          check("t5_din_ready", 64'(din_ready), 64'd0);
          check_blk("t5_blk_held", blk, saved);
        end
        tick();
        hold_ack = 1'b0;
      end
    join
    drain();

    // Reset after 5 words of an unfinished message.
    mode = 2'b00;
    for (int w = 0; w < 5; w++) send_word({$urandom, $urandom}, 1'b0, 4'd8);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_blk("t6_blk", blk, '0);
    check("t6_blk_valid", 64'(blk_valid), 64'd0);
    check("t6_din_ready", 64'(din_ready), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    rand_msg(10, m);
    send_msg(m, 2'b00, 1'b0);
    drain();

    // Random messages, lengths biased toward block boundaries.
    for (int i = 0; i < 30; i++) begin
      rate = 168;
      case ($urandom_range(0, 2))
        0:       L = $urandom_range(0, 400);
        1:       L = 136 * $urandom_range(1, 2) + $urandom_range(0, 2) - 1;
        default: L = rate * $urandom_range(1, 2) + $urandom_range(0, 2) - 1;
      endcase
      rand_msg(L, m);
      send_msg(m, 2'($urandom_range(0, 3)), 1'b1);
    end
    drain();

    check("msg_done_count", 64'(done_seen), 64'(msgs_sent));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
